fir_mac_filter: RTL and testbench
=================================

# fir_mac_filter

Parametrised, time-multiplexed FIR filter: the next-generation replacement for the fixed 21-tap direct-form filter in the sample datapath. It uses one multiplier-accumulator iterated across the taps, with a run-time writable coefficient bank and an optional symmetric (folded) mode that halves the MAC cycles. It adds rounding shift, output saturation, an output-valid strobe and overrun detection. It sits between the 600 kHz sample source and the downstream output stage, clocked at 12 MHz.

## Interface
- DATA_W, 3: signed input sample width
- COEF_W, 16: signed coefficient width
- TAPS, 21: filter length, 2..64
- SYM, 1: 1 = symmetric folded mode, 0 = direct mode
- ACC_W, 32: accumulator width; must be ≥ DATA_W+1+COEF_W+clog2(TAPS)
- OUT_W, 16: signed output width
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation, 0..ACC_W-OUT_W
- iClk_12MHz  in  1  system clock
- iRst  in  1  asynchronous, active-high reset
- iEnSample_600kHz  in  1  sample strobe; iFirIn is valid in this cycle
- iFirIn  in  DATA_W  signed input sample
- iCoefWe  in  1  coefficient write enable
- iCoefAddr  in  6  coefficient index
- iCoefData  in  COEF_W  signed coefficient value
- oFirOut  out  OUT_W  signed filtered output, held between updates
- oFirValid  out  1  one-cycle pulse when oFirOut updates
- oSat  out  1  saturation occurred on this output; valid with oFirValid and held until the next update
- oBusy  out  1  MAC sequence in progress
- oOverrun  out  1  one-cycle pulse when a sample strobe is dropped
- oCoefErr  out  1  one-cycle pulse when a coefficient write is rejected

## Operation
- Sample buffer: circular store of TAPS signed samples with a write pointer wp. An accepted strobe writes iFirIn at wp. wp then advances and wraps from TAPS-1 to 0. x[k] denotes the sample k strobes old, with x[0] the newest.
- Coefficient bank: TAPS entries, all 0 after reset.
  - SYM=1: only addresses 0..ceil(TAPS/2)-1 are used. Coefficient c[k] applies to x[k] and x[TAPS-1-k].
  - SYM=0: coefficient c[k] applies to x[k].
- FSM states:
  - IDLE → MAC on an accepted strobe; the accumulator is cleared.
  - MAC runs N cycles, where N = ceil(TAPS/2) if SYM=1, else TAPS. Step k adds c[k]·x[k] to the accumulator.
    - In SYM=1 with k < TAPS/2, step k instead adds c[k]·(x[k]+x[TAPS-1-k]). The pre-add is DATA_W+1 bits.
    - In SYM=1 with odd TAPS, the middle step uses x[k] alone.
  - After step N-1, MAC → DONE.
  - DONE → IDLE in one cycle: the output registers load and oFirValid pulses.
- Arithmetic:
  - Products and the accumulator are signed and sign-extended to ACC_W.
  - Result = acc >>> SHIFT (arithmetic shift, truncating).
  - If the result exceeds 2^(OUT_W-1)-1, output 0x7FFF-equivalent; if below -2^(OUT_W-1), output the minimum value. In both cases oSat=1, otherwise oSat=0.
- oBusy=1 in the MAC and DONE states.
- A strobe while oBusy=1 is dropped: no buffer write, no wp change, oOverrun pulses, and the sequence in progress is unaffected.
- iCoefWe while oBusy=0 writes the bank in the same cycle.
  - iCoefWe while oBusy=1 is ignored and oCoefErr pulses.
  - An address ≥ TAPS is ignored and oCoefErr pulses.
- A strobe and a coefficient write in the same IDLE cycle: the write takes effect, then MAC uses the new value.

## Timing
- Reset (asynchronous, any state including mid-MAC):
  - Outputs: oFirOut=0, oFirValid=0, oSat=0, oBusy=0, oOverrun=0, oCoefErr=0.
  - Internal: state=IDLE, wp=0, all buffer samples 0, all coefficients 0, accumulator 0.
  - The interrupted result is never output.
- Strobe accepted at cycle t:
  - oBusy=1 from t+1.
  - MAC occupies t+1..t+N and DONE is t+N+1.
  - oFirOut, oSat and the oFirValid pulse appear at t+N+2.
  - oBusy=0 at t+N+2. A strobe in cycle t+N+2 is accepted.
- Latency from strobe to valid is N+2 clocks. Defaults (SYM=1, TAPS=21): N=11, latency 13, within the 20-clock sample period.
- SYM=0 with TAPS=21 needs 23 clocks per sample, so a 600 kHz strobe overruns on alternate samples. This is legal and flagged.
- oOverrun and oCoefErr assert in the cycle after the offending input.

## Test plan
- Impulse response, SYM=1 defaults:
  - Stimulus: c[k]=k+1 for k=0..10; iFirIn=1 then 0 on following strobes.
  - Required: 21 oFirOut values 1,2,…,11,10,…,1, then 0. oSat=0. Each oFirValid arrives 13 clocks after its strobe.
- Mode equivalence:
  - Stimulus: SYM=0, TAPS=21, full mirrored bank (same c[k] as above); strobe every 24 clocks; same random iFirIn sequence in −4..3 as the SYM=1 run.
  - Required: output sequence identical to SYM=1; oOverrun never asserts.
- Saturation:
  - Stimulus: all coefficients 0x7FFF; iFirIn=3 held.
  - Required: oFirOut=0x7FFF with oSat=1 once the sum exceeds 32767.
  - Stimulus: iFirIn=−4 held.
  - Required: oFirOut=0x8000 with oSat=1.
- Overrun:
  - Stimulus: a strobe 5 clocks after an accepted strobe.
  - Required: oOverrun pulses once, that sample is absent from later outputs, and the in-flight output is unchanged.
- Coefficient write rejection:
  - Stimulus: iCoefWe during MAC; separately, iCoefAddr=25.
  - Required: oCoefErr pulses for each; bank unchanged, verified by a following impulse.
- Reset mid-MAC:
  - Stimulus: assert iRst 4 clocks into MAC.
  - Required: all outputs 0 immediately with no oFirValid. After release, a strobe with iFirIn=3 gives oFirOut=0, because the bank has been cleared.

Source files
------------

// File: rtl/fir_mac_filter.sv
// fir_mac_filter: time-multiplexed FIR filter with one MAC, writable coefficient bank and optional folded mode
module fir_mac_filter #(
   parameter int DATA_W = 3,
   parameter int COEF_W = 16,
   parameter int TAPS   = 21,
   parameter int SYM    = 1,
   parameter int ACC_W  = 32,
   parameter int OUT_W  = 16,
   parameter int SHIFT  = 0
) (
   input  logic                     iClk_12MHz,
   input  logic                     iRst,
   input  logic                     iEnSample_600kHz,
   input  logic signed [DATA_W-1:0] iFirIn,
   input  logic                     iCoefWe,
   input  logic [5:0]               iCoefAddr,
   input  logic signed [COEF_W-1:0] iCoefData,
   output logic signed [OUT_W-1:0]  oFirOut,
   output logic                     oFirValid,
   output logic                     oSat,
   output logic                     oBusy,
   output logic                     oOverrun,
   output logic                     oCoefErr
);
   localparam int AW = $clog2(TAPS);
   localparam int N  = (SYM != 0) ? (TAPS + 1) / 2 : TAPS;
   localparam int PW = DATA_W + 1 + COEF_W;
   localparam logic [1:0] IDLE = 2'd0, MAC = 2'd1, DONE = 2'd2;
   localparam logic [AW-1:0] LAST = AW'(TAPS - 1), KEND = AW'(N - 1), HALF = AW'(TAPS / 2);
   localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

   logic [1:0] state_q, state_d;
   logic [AW-1:0] wp_q, wp_d, ra_q, rb_q, k_q;
   logic signed [DATA_W-1:0] x_q [TAPS];
   logic signed [COEF_W-1:0] c_q [TAPS];
   logic signed [ACC_W-1:0] acc_q, res;
   logic signed [DATA_W:0] xs;
   logic signed [PW-1:0] prod;
   logic signed [OUT_W-1:0] out_d;
   logic busy, take, we_ok, sat_hi, sat_lo;

   assign busy  = state_q != IDLE;
   assign oBusy = busy;
   assign take  = iEnSample_600kHz && !busy;
   assign we_ok = iCoefWe && !busy && ({1'b0, iCoefAddr} < 7'(TAPS));

   // next state, write pointer and the folded MAC term; ra walks newest->older, rb oldest->newer
   always_comb begin
      state_d = state_q == IDLE ? (take ? MAC : IDLE) : state_q == MAC ? (k_q == KEND ? DONE : MAC) : IDLE;
      wp_d    = wp_q == LAST ? '0 : wp_q + 1'b1;
      xs      = (SYM != 0 && k_q < HALF) ? {x_q[ra_q][DATA_W-1], x_q[ra_q]} + {x_q[rb_q][DATA_W-1], x_q[rb_q]}
                                         : {x_q[ra_q][DATA_W-1], x_q[ra_q]};
      prod    = {{COEF_W{xs[DATA_W]}}, xs} * {{(DATA_W+1){c_q[k_q][COEF_W-1]}}, c_q[k_q]};
      res     = acc_q >>> SHIFT;
      sat_hi  = res > MAXV;
      sat_lo  = res < MINV;
      out_d   = sat_hi ? {1'b0, {(OUT_W-1){1'b1}}} : sat_lo ? {1'b1, {(OUT_W-1){1'b0}}} : res[OUT_W-1:0];
   end

   // control, accumulator and output registers
   always_ff @(posedge iClk_12MHz or posedge iRst) begin
      if (iRst) begin
         state_q   <= IDLE;
         wp_q      <= '0;
         ra_q      <= '0;
         rb_q      <= '0;
         k_q       <= '0;
         acc_q     <= '0;
         oFirOut   <= '0;
         oFirValid <= 1'b0;
         oSat      <= 1'b0;
         oOverrun  <= 1'b0;
         oCoefErr  <= 1'b0;
      end else begin
         state_q   <= state_d;
         oFirValid <= state_q == DONE;
         oOverrun  <= iEnSample_600kHz && busy;
         oCoefErr  <= iCoefWe && !we_ok;
         if (take) begin
            wp_q  <= wp_d;
            ra_q  <= wp_q;
            rb_q  <= wp_d;
            k_q   <= '0;
            acc_q <= '0;
         end else if (state_q == MAC) begin
            acc_q <= acc_q + {{(ACC_W-PW){prod[PW-1]}}, prod};
            k_q   <= k_q + 1'b1;
            ra_q  <= ra_q == '0 ? LAST : ra_q - 1'b1;
            rb_q  <= rb_q == LAST ? '0 : rb_q + 1'b1;
         end
         if (state_q == DONE) begin
            oFirOut <= out_d;
            oSat    <= sat_hi || sat_lo;
         end
      end
   end

   // sample buffer and coefficient bank
   always_ff @(posedge iClk_12MHz or posedge iRst) begin
      if (iRst) begin
         for (int i = 0; i < TAPS; i++) begin
            x_q[i] <= '0;
            c_q[i] <= '0;
         end
      end else begin
         if (take) x_q[wp_q] <= iFirIn;
         if (we_ok) c_q[iCoefAddr[AW-1:0]] <= iCoefData;
      end
   end
endmodule

// File: tb/tb_fir_mac_filter.sv
// tb_fir_mac_filter: folded and direct filters driven in lockstep and checked against a tap-sum model
module tb_fir_mac_filter;
   localparam int TAPS = 21;
   logic clk = 0, rst = 0, stb = 0, we = 0;
   logic signed [2:0] din = 0;
   logic [5:0] addr = 0;
   logic signed [15:0] cdat = 0;
   logic signed [15:0] out0, out1;
   logic val0, val1, sat0, sat1, bsy0, bsy1, ovr0, ovr1, err0, err1;
   int nasrt = 0, nfail = 0;
   int hist [TAPS];
   int cm [TAPS];
   int y0, y1;

   always #5 clk = ~clk;

   fir_mac_filter #(.SYM(1)) u1 (.iClk_12MHz(clk), .iRst(rst), .iEnSample_600kHz(stb), .iFirIn(din),
      .iCoefWe(we), .iCoefAddr(addr), .iCoefData(cdat), .oFirOut(out1), .oFirValid(val1), .oSat(sat1),
      .oBusy(bsy1), .oOverrun(ovr1), .oCoefErr(err1));
   fir_mac_filter #(.SYM(0)) u0 (.iClk_12MHz(clk), .iRst(rst), .iEnSample_600kHz(stb), .iFirIn(din),
      .iCoefWe(we), .iCoefAddr(addr), .iCoefData(cdat), .oFirOut(out0), .oFirValid(val0), .oSat(sat0),
      .oBusy(bsy0), .oOverrun(ovr0), .oCoefErr(err0));

   task automatic chk(input string tag, input logic signed [31:0] o, input logic signed [31:0] e);
      nasrt++;
      assert (o === e) else begin
         nfail++;
         $error("FAIL %s: got %0d expected %0d", tag, o, e);
      end
   endtask

   function automatic int model(input int sym);
      int y = 0;
      for (int k = 0; k < TAPS; k++) y += hist[k] * (sym != 0 ? cm[k < TAPS-1-k ? k : TAPS-1-k] : cm[k]);
      return y;
   endfunction

   function automatic int clampv(input int y);
      return y > 32767 ? 32767 : y < -32768 ? -32768 : y;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wcoef(input int a, input int v);
      we = 1; addr = 6'(a); cdat = 16'(v);
      tick();
      we = 0;
      chk("coef_err0", err0, a >= TAPS);
      chk("coef_err1", err1, a >= TAPS);
      if (a < TAPS) cm[a] = v;
   endtask

   // kind 0: plain sample, 1: extra strobe 5 cycles later, 2: coefficient write 5 cycles later
   task automatic sample(input int v, input int kind, output int r1, output int r0);
      int lat = 1, got0 = 0, got1 = 0, l0 = 0, l1 = 0, o0 = 0, o1 = 0, s0 = 0, s1 = 0;
      int nov0 = 0, nov1 = 0, ne0 = 0, ne1 = 0, ovl = 0, e;
      stb = 1; din = 3'(v);
      tick();
      stb = 0;
      for (int k = TAPS-1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = v;
      chk("busy_start1", bsy1, 1);
      chk("busy_start0", bsy0, 1);
      while (!(got0 != 0 && got1 != 0) && lat < 40) begin
         if (kind == 1 && lat == 5) begin stb = 1; din = 3'($urandom_range(0, 7)); end
         if (kind == 2 && lat == 5) begin we = 1; addr = 6'd3; cdat = 16'h1234; end
         tick();
         lat++;
         stb = 0; we = 0;
         nov0 += int'(ovr0); nov1 += int'(ovr1); ne0 += int'(err0); ne1 += int'(err1);
         if (ovr1) ovl = lat;
         if (val0 && got0 == 0) begin got0 = 1; l0 = lat; o0 = out0; s0 = sat0; chk("busy_end0", bsy0, 0); end
         if (val1 && got1 == 0) begin got1 = 1; l1 = lat; o1 = out1; s1 = sat1; chk("busy_end1", bsy1, 0); end
      end
      e = model(1);
      chk("out1", o1, clampv(e));
      chk("sat1", s1, e != clampv(e));
      chk("lat1", l1, 13);
      e = model(0);
      chk("out0", o0, clampv(e));
      chk("sat0", s0, e != clampv(e));
      chk("lat0", l0, 23);
      chk("ovr_cnt1", nov1, kind == 1);
      chk("ovr_cnt0", nov0, kind == 1);
      chk("ovr_cycle", ovl, kind == 1 ? 6 : 0);
      chk("cerr_cnt1", ne1, kind == 2);
      chk("cerr_cnt0", ne0, kind == 2);
      r1 = o1;
      r0 = o0;
   endtask

   initial begin
      for (int k = 0; k < TAPS; k++) begin hist[k] = 0; cm[k] = 0; end
      #1 rst = 1;
      #2;
      chk("rst_out1", out1, 0); chk("rst_val1", val1, 0); chk("rst_sat1", sat1, 0);
      chk("rst_busy1", bsy1, 0); chk("rst_ovr1", ovr1, 0); chk("rst_err1", err1, 0);
      chk("rst_out0", out0, 0); chk("rst_busy0", bsy0, 0);
      tick(); tick();
      rst = 0;
      tick();
      // impulse response with mirrored bank 1..11..1
      for (int k = 0; k < TAPS; k++) wcoef(k, k < TAPS-1-k ? k+1 : TAPS-k);
      for (int i = 0; i < 22; i++) begin
         sample(i == 0 ? 1 : 0, 0, y1, y0);
         chk("impulse_const", y1, i < 21 ? (i <= 10 ? i+1 : 21-i) : 0);
      end
      // random samples, both modes must agree
      for (int i = 0; i < 30; i++) begin
         sample(int'($urandom_range(0, 7)) - 4, 0, y1, y0);
         chk("equiv", y0, y1);
      end
      // dropped strobe and rejected write while busy, then out-of-range address
      sample(int'($urandom_range(0, 7)) - 4, 1, y1, y0);
      sample(int'($urandom_range(0, 7)) - 4, 2, y1, y0);
      wcoef(25, 16'h0BAD);
      for (int i = 0; i < 21; i++) sample(i == 0 ? 1 : 0, 0, y1, y0);
      // random, unmirrored bank: each mode uses its own coefficients
      for (int k = 0; k < TAPS; k++) wcoef(k, int'($urandom_range(0, 65535)) - 32768);
      for (int i = 0; i < 20; i++) sample(int'($urandom_range(0, 7)) - 4, 0, y1, y0);
      // saturation at both rails
      for (int k = 0; k < TAPS; k++) wcoef(k, 32767);
      for (int i = 0; i < 21; i++) sample(3, 0, y1, y0);
      chk("sat_hi_const", y1, 32767);
      for (int i = 0; i < 21; i++) sample(-4, 0, y1, y0);
      chk("sat_lo_const", y1, -32768);
      // reset in the middle of a MAC sequence
      stb = 1; din = 3'sd1;
      tick();
      stb = 0;
      repeat (4) tick();
      #2 rst = 1;
      #1;
      chk("mid_rst_out1", out1, 0); chk("mid_rst_busy1", bsy1, 0); chk("mid_rst_val1", val1, 0);
      chk("mid_rst_sat1", sat1, 0); chk("mid_rst_busy0", bsy0, 0); chk("mid_rst_out0", out0, 0);
      tick(); tick();
      rst = 0;
      begin
         int nv = 0;
         repeat (30) begin tick(); nv += int'(val1) + int'(val0); end
         chk("no_valid_after_rst", nv, 0);
      end
      for (int k = 0; k < TAPS; k++) begin hist[k] = 0; cm[k] = 0; end
      sample(3, 0, y1, y0);
      chk("cleared_bank1", y1, 0);
      chk("cleared_bank0", y0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
      $finish;
   end
endmodule
